// File: rtl/multi_debouncer.sv
// Per-channel button debouncer: 2-flop synchronizer, stability counter, press/release pulses.
// Define DEBOUNCE_AUTOREPEAT_EN to add held-key auto-repeat; release/repeat are SV keywords, hence the _pulse port names.
module multi_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 2500,
    parameter int REPEAT_PERIOD = 500
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_meta;
    logic [CHANNELS-1:0] sync;
    logic [CHANNELS-1:0] flip;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= button;
            sync      <= sync_meta;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [CNT_W-1:0] cnt;

        // flip: sync has disagreed with debounced for STABLE_CYCLES consecutive samples
        assign flip[ch] = (sync[ch] != debounced[ch]) && (cnt == CNT_LAST);

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
            end else if ((sync[ch] == debounced[ch]) || flip[ch]) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            debounced     <= '0;
            press         <= '0;
            release_pulse <= '0;
        end else begin
            debounced     <= debounced ^ flip;
            press         <= flip & ~debounced;
            release_pulse <= flip & debounced;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int                RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                RPT_W       = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_rpt
        logic [RPT_W-1:0] rpt_cnt;
        logic             rpt_q;

        // Any debounced edge reloads the delay, so the release edge can never emit a repeat.
        always_ff @(posedge clk) begin
            if (reset) begin
                rpt_cnt <= '0;
                rpt_q   <= 1'b0;
            end else if (flip[ch]) begin
                rpt_cnt <= DELAY_LOAD;
                rpt_q   <= 1'b0;
            end else if (debounced[ch]) begin
                if (rpt_cnt == '0) begin
                    rpt_cnt <= PERIOD_LOAD;
                    rpt_q   <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_cnt - 1'b1;
                    rpt_q   <= 1'b0;
                end
            end else begin
                rpt_q <= 1'b0;
            end
        end

        assign repeat_pulse[ch] = rpt_q;
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign repeat_pulse      = '0;
`endif

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter CHANNELS, default 4, is the number of independent button inputs (range 1..32).
REQ-002 Parameter STABLE_CYCLES, default 16, is the number of consecutive synchronized samples that must differ from the current debounced state before that state changes (range 1..65535).
REQ-003 Parameter REPEAT_DELAY, default 2500, is the number of held cycles from the press pulse to the first repeat pulse (only used with DEBOUNCE_AUTOREPEAT_EN, minimum 1).
REQ-004 Parameter REPEAT_PERIOD, default 500, is the number of cycles between later repeat pulses (only used with DEBOUNCE_AUTOREPEAT_EN, minimum 1).
REQ-005 clk  input  1  single clock for all logic, nominally 5 kHz.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 button  input  CHANNELS  raw asynchronous button levels, one bit per channel.
REQ-008 debounced  output  CHANNELS  registered debounced level per channel.
REQ-009 press  output  CHANNELS  one-cycle pulse on each debounced 0->1 transition.
REQ-010 release  output  CHANNELS  one-cycle pulse on each debounced 1->0 transition.
REQ-011 repeat  output  CHANNELS  one-cycle auto-repeat pulse; constant 0 when DEBOUNCE_AUTOREPEAT_EN is undefined.

Function
REQ-012 Each channel shall be fully independent, with no shared counters or cross-channel interaction.
REQ-013 Each button bit shall pass through a 2-flop synchronizer; only the second stage (sync) feeds the debounce logic.
REQ-014 Per channel, a counter cnt of width $clog2(STABLE_CYCLES+1) shall update each edge: sync==debounced -> cnt<=0; sync!=debounced and cnt==STABLE_CYCLES-1 -> debounced<=sync, cnt<=0; otherwise cnt<=cnt+1.
REQ-015 Any sample equal to the current debounced state shall restart the count, so a glitch shorter than STABLE_CYCLES never changes the output.
REQ-016 A clean input step that is stable from sampling edge k shall change debounced at edge k+STABLE_CYCLES+1, a latency of STABLE_CYCLES+2 edges.
REQ-017 press (release) shall be asserted for exactly the one cycle following the edge on which debounced goes 1 (0), and shall be registered in the same edge as debounced.
REQ-018 STABLE_CYCLES=1 shall change debounced one edge after sync changes, with no counting.
REQ-019 The counters shall never wrap: cnt shall stay at or below STABLE_CYCLES-1.

Reset
REQ-020 While reset is high at a clk edge, the synchronizer flops, cnt, repeat counters, debounced, press, release and repeat shall all clear to 0.
REQ-021 A reset asserted mid-count or mid-hold shall discard the count; no press, release or repeat pulse shall be emitted for the reset edge or the cycle after it.
REQ-022 After reset, a button held high shall behave as a new press, with full REQ-016 latency and a press pulse.

Configuration
REQ-023 With macro DEBOUNCE_AUTOREPEAT_EN defined, each channel shall hold a repeat counter of width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1) that loads on the press edge.
REQ-024 With DEBOUNCE_AUTOREPEAT_EN defined, repeat shall pulse REPEAT_DELAY cycles after the press pulse and then every REPEAT_PERIOD cycles while debounced stays 1.
REQ-025 With DEBOUNCE_AUTOREPEAT_EN defined, a release shall stop repeats immediately, and repeat shall never coincide with press or release.
REQ-026 With DEBOUNCE_AUTOREPEAT_EN undefined, no repeat counters shall be synthesized and repeat shall be tied to 0.

Verification
REQ-027 CHANNELS=4, STABLE_CYCLES=8: button[0] 0->1 held -> debounced[0] rises at 10th edge from the first sampling edge; press[0] high for 1 cycle; other channels stay 0.
REQ-028 STABLE_CYCLES=8: button[1] bounces 1,0,1,0 every 3 cycles, then holds 1 -> no output activity during the bounce; debounced[1] rises 10 edges after the final stable 1.
REQ-029 Channel 2 pressed, then released after 50 cycles -> exactly one press[2] and one release[2] pulse, each 1 cycle wide, and release lagging the button fall by 10 edges.
REQ-030 Reset asserted 4 cycles into a valid press on channel 3 -> all outputs 0; with button still held after reset release, press[3] fires 10 edges later.
REQ-031 DEBOUNCE_AUTOREPEAT_EN defined, REPEAT_DELAY=20, REPEAT_PERIOD=5, channel 0 held for 40 cycles after press -> repeat[0] at +20, +25, +30, +35 cycles after press; none after release.
REQ-032 All four channels toggled on the same cycle -> all four press bits asserted together in one cycle.
